ahb_uart16550: RTL and testbench

AHB-Lite slave wrapping a simplified 16550-compatible UART: 8N1 serial line, 16x-oversampled receiver, TX/RX FIFOs, modem-control pins and a level interrupt. It sits on the SCR1 data-memory AHB bus at base 0x0000_0000, with registers on a 4-byte stride (HADDR[4:2]). UART_INT drives the core's external IRQ line 0.

---
 rtl/ahb_uart16550_pkg.sv | 42 ++++
 rtl/ahb_uart16550_fifo.sv | 53 +++++
 rtl/ahb_uart16550.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ahb_uart16550.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_uart16550_pkg.sv
// Shared constants and types for the AHB-Lite 16550-style UART.
package ahb_uart16550_pkg;

  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_IIR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7;

  localparam logic [3:0] IIR_RLS  = 4'h6;
  localparam logic [3:0] IIR_RDA  = 4'h4;
  localparam logic [3:0] IIR_THRE = 4'h2;
  localparam logic [3:0] IIR_MS   = 4'h0;
  localparam logic [3:0] IIR_NONE = 4'h1;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam int IER_RDA  = 0;
  localparam int IER_THRE = 1;
  localparam int IER_RLS  = 2;
  localparam int IER_MS   = 3;

  localparam int LCR_DLAB = 7;
  localparam int MCR_LOOP = 4;

  localparam logic [7:0] LCR_RESET = 8'h03;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/ahb_uart16550_fifo.sv
// Synchronous FIFO with full/empty/count; a push and pop in the same cycle are both honoured.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s, do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wptr_r] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else if (clr) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) wptr_r <= wptr_r + AW'(1);
      if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
      count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

endmodule

// File: rtl/ahb_uart16550.sv
// AHB-Lite slave wrapping an 8N1 16550-style UART with TX/RX FIFOs, modem pins and a level IRQ.
module ahb_uart16550 #(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] RESET_DIVISOR = 16'd1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        SI_Endian,
  input  logic        UART_SRX,
  output logic        UART_STX,
  output logic        UART_RTS,
  input  logic        UART_CTS,
  output logic        UART_DTR,
  input  logic        UART_DSR,
  input  logic        UART_RI,
  input  logic        UART_DCD,
  output logic        UART_INT
);
  import ahb_uart16550_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic dp_valid_r, dp_write_r;
  logic [2:0] dp_addr_r;
  logic [7:0] wr_byte_s, rd_byte_s, lsr_s, lcr_r, scr_r, dll_r, dlm_r;
  logic [3:0] ier_r, iir_code_s, modem_meta_r, modem_sync_r, modem_s, msr_r, msr_delta_r, msr_chg_s;
  logic [4:0] mcr_r;
  logic [15:0] divisor_s, baud_cnt_r;
  logic wr_en_s, rd_en_s, dlab_s, thr_wr_s, rbr_rd_s, lsr_rd_s, msr_rd_s, iir_rd_s, ier_wr_s, fcr_wr_s;
  logic tick_s, tx_empty_s, tx_full_s, rx_empty_s, rx_full_s, tx_pop_s, rx_pop_s, rx_push_s, rx_fe_s, rx_ovr_s;
  logic [7:0] tx_rdata_s, rx_rdata_s;
  logic [CW-1:0] tx_count_s, rx_count_s;
  logic lsr_oe_r, lsr_fe_r, thre_flag_r, tx_empty_d_r, int_r, stx_r, thre_set_s, thre_clr_s;
  logic srx_meta_r, srx_sync_r, srx_prev_r, rx_in_s, tx_line_s;
  ser_state_e tx_state_r, tx_state_s, rx_state_r, rx_state_s;
  logic [3:0] tx_tick_r, tx_tick_s, rx_tick_r, rx_tick_s;
  logic [2:0] tx_bitn_r, tx_bitn_s, rx_bitn_r, rx_bitn_s;
  logic [7:0] tx_shift_r, tx_shift_s, rx_shift_r, rx_shift_s;
  logic unused_s;

  assign unused_s = ^{HADDR[31:5], HADDR[1:0], HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS[0],
                      HWDATA[23:8], tx_count_s, rx_count_s, tx_full_s};

  assign HREADY    = 1'b1;
  assign HRESP     = 1'b0;
  assign UART_STX  = stx_r;
  assign UART_RTS  = ~mcr_r[1];
  assign UART_DTR  = ~mcr_r[0];
  assign UART_INT  = int_r;

  assign wr_byte_s = SI_Endian ? HWDATA[7:0] : HWDATA[31:24];
  assign wr_en_s   = dp_valid_r & dp_write_r;
  assign rd_en_s   = dp_valid_r & ~dp_write_r;
  assign dlab_s    = lcr_r[LCR_DLAB];
  assign thr_wr_s  = wr_en_s & (dp_addr_r == REG_RBR) & ~dlab_s;
  assign ier_wr_s  = wr_en_s & (dp_addr_r == REG_IER) & ~dlab_s;
  assign fcr_wr_s  = wr_en_s & (dp_addr_r == REG_IIR);
  assign rbr_rd_s  = rd_en_s & (dp_addr_r == REG_RBR) & ~dlab_s;
  assign iir_rd_s  = rd_en_s & (dp_addr_r == REG_IIR);
  assign lsr_rd_s  = rd_en_s & (dp_addr_r == REG_LSR);
  assign msr_rd_s  = rd_en_s & (dp_addr_r == REG_MSR);
  assign rx_pop_s  = rbr_rd_s & ~rx_empty_s;
  assign rx_ovr_s  = rx_push_s & rx_full_s & ~rx_pop_s;
  assign HRDATA    = rd_en_s ? (SI_Endian ? {24'h000000, rd_byte_s} : {rd_byte_s, 24'h000000}) : 32'h00000000;

  // Address phase capture; the data phase is always the following cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_addr_r  <= 3'd0;
    end else begin
      dp_valid_r <= HSEL & HTRANS[1];
      dp_write_r <= HWRITE;
      dp_addr_r  <= HADDR[4:2];
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ier_r <= 4'h0;  lcr_r <= LCR_RESET;  mcr_r <= 5'h00;  scr_r <= 8'h00;
      dll_r <= RESET_DIVISOR[7:0];  dlm_r <= RESET_DIVISOR[15:8];
    end else if (wr_en_s) begin
      case (dp_addr_r)
        REG_RBR: if (dlab_s) dll_r <= wr_byte_s;
        REG_IER: if (dlab_s) dlm_r <= wr_byte_s; else ier_r <= wr_byte_s[3:0];
        REG_LCR: lcr_r <= wr_byte_s;
        REG_MCR: mcr_r <= wr_byte_s[4:0];
        REG_SCR: scr_r <= wr_byte_s;
        default: ;
      endcase
    end
  end

  // 16x baud tick; a zero divisor parks the counter and freezes both serial engines.
  assign divisor_s = {dlm_r, dll_r};
  assign tick_s    = (divisor_s != 16'd0) && (baud_cnt_r >= divisor_s - 16'd1);
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) baud_cnt_r <= 16'd0;
    else if ((divisor_s == 16'd0) || tick_s) baud_cnt_r <= 16'd0;
    else baud_cnt_r <= baud_cnt_r + 16'd1;
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(HCLK), .rst(HRESET), .clr(fcr_wr_s & wr_byte_s[2]), .push(thr_wr_s), .pop(tx_pop_s),
    .wdata(wr_byte_s), .rdata(tx_rdata_s), .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s));

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(HCLK), .rst(HRESET), .clr(fcr_wr_s & wr_byte_s[1]), .push(rx_push_s), .pop(rx_pop_s),
    .wdata(rx_shift_r), .rdata(rx_rdata_s), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s));

  // Serial engine state registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tx_state_r <= SER_IDLE;  tx_tick_r <= 4'd0;  tx_bitn_r <= 3'd0;  tx_shift_r <= 8'h00;
      rx_state_r <= SER_IDLE;  rx_tick_r <= 4'd0;  rx_bitn_r <= 3'd0;  rx_shift_r <= 8'h00;
    end else begin
      tx_state_r <= tx_state_s;  tx_tick_r <= tx_tick_s;  tx_bitn_r <= tx_bitn_s;  tx_shift_r <= tx_shift_s;
      rx_state_r <= rx_state_s;  rx_tick_r <= rx_tick_s;  rx_bitn_r <= rx_bitn_s;  rx_shift_r <= rx_shift_s;
    end
  end

  // Transmitter next state: the FIFO is popped as the start bit begins.
  always_comb begin
    tx_state_s = tx_state_r;  tx_bitn_s = tx_bitn_r;  tx_shift_s = tx_shift_r;
    tx_tick_s  = tick_s ? tx_tick_r + 4'd1 : tx_tick_r;
    tx_pop_s   = 1'b0;
    tx_line_s  = 1'b1;
    case (tx_state_r)
      SER_IDLE: begin
        tx_tick_s = 4'd0;
        if (tick_s && !tx_empty_s) begin
          tx_state_s = SER_START;  tx_pop_s = 1'b1;  tx_shift_s = tx_rdata_s;
        end else begin
          tx_state_s = SER_IDLE;
        end
      end
      SER_START: begin
        tx_line_s = 1'b0;
        if (tick_s && tx_tick_r == 4'd15) begin tx_state_s = SER_DATA; tx_bitn_s = 3'd0; end
        else begin tx_state_s = SER_START; end
      end
      SER_DATA: begin
        tx_line_s = tx_shift_r[0];
        if (tick_s && tx_tick_r == 4'd15) begin
          tx_shift_s = {1'b0, tx_shift_r[7:1]};
          tx_bitn_s  = tx_bitn_r + 3'd1;
          tx_state_s = (tx_bitn_r == 3'd7) ? SER_STOP : SER_DATA;
        end else begin
          tx_state_s = SER_DATA;
        end
      end
      SER_STOP: begin
        if (tick_s && tx_tick_r == 4'd15) tx_state_s = SER_IDLE;
        else tx_state_s = SER_STOP;
      end
      default: tx_state_s = SER_IDLE;
    endcase
  end

  // Receiver next state: start confirmed half a bit in, then one sample per bit at mid-bit.
  always_comb begin
    rx_state_s = rx_state_r;  rx_bitn_s = rx_bitn_r;  rx_shift_s = rx_shift_r;
    rx_tick_s  = tick_s ? rx_tick_r + 4'd1 : rx_tick_r;
    rx_push_s  = 1'b0;
    rx_fe_s    = 1'b0;
    case (rx_state_r)
      SER_IDLE: begin
        rx_tick_s = 4'd0;
        if (srx_prev_r && !srx_sync_r) rx_state_s = SER_START;
        else rx_state_s = SER_IDLE;
      end
      SER_START: begin
        if (tick_s && rx_tick_r == 4'd7) begin
          rx_tick_s  = 4'd0;
          rx_bitn_s  = 3'd0;
          rx_state_s = srx_sync_r ? SER_IDLE : SER_DATA;
        end else begin
          rx_state_s = SER_START;
        end
      end
      SER_DATA: begin
        if (tick_s && rx_tick_r == 4'd15) begin
          rx_shift_s = {srx_sync_r, rx_shift_r[7:1]};
          rx_bitn_s  = rx_bitn_r + 3'd1;
          rx_state_s = (rx_bitn_r == 3'd7) ? SER_STOP : SER_DATA;
        end else begin
          rx_state_s = SER_DATA;
        end
      end
      SER_STOP: begin
        if (tick_s && rx_tick_r == 4'd15) begin
          rx_push_s = 1'b1;  rx_fe_s = ~srx_sync_r;  rx_state_s = SER_IDLE;
        end else begin
          rx_state_s = SER_STOP;
        end
      end
      default: rx_state_s = SER_IDLE;
    endcase
  end

  // Input synchronisers; loopback routes the TX line into RX before synchronisation.
  assign rx_in_s = mcr_r[MCR_LOOP] ? tx_line_s : UART_SRX;
  assign modem_s = mcr_r[MCR_LOOP] ? {mcr_r[3], mcr_r[2], mcr_r[0], mcr_r[1]} : ~modem_sync_r;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      srx_meta_r <= 1'b1;  srx_sync_r <= 1'b1;  srx_prev_r <= 1'b1;
      modem_meta_r <= 4'hF;  modem_sync_r <= 4'hF;
    end else begin
      srx_meta_r <= rx_in_s;  srx_sync_r <= srx_meta_r;  srx_prev_r <= srx_sync_r;
      modem_meta_r <= {UART_DCD, UART_RI, UART_DSR, UART_CTS};
      modem_sync_r <= modem_meta_r;
    end
  end

  // Interrupt source priority; bit0 low means an interrupt is pending.
  always_comb begin
    if (ier_r[IER_RLS] && (lsr_oe_r || lsr_fe_r)) iir_code_s = IIR_RLS;
    else if (ier_r[IER_RDA] && !rx_empty_s) iir_code_s = IIR_RDA;
    else if (ier_r[IER_THRE] && tx_empty_s && thre_flag_r) iir_code_s = IIR_THRE;
    else if (ier_r[IER_MS] && (|msr_delta_r)) iir_code_s = IIR_MS;
    else iir_code_s = IIR_NONE;
  end

  // Line status assembly.
  always_comb begin
    lsr_s = 8'h00;
    lsr_s[LSR_DR]   = ~rx_empty_s;
    lsr_s[LSR_OE]   = lsr_oe_r;
    lsr_s[LSR_FE]   = lsr_fe_r;
    lsr_s[LSR_THRE] = tx_empty_s;
    lsr_s[LSR_TEMT] = tx_empty_s & (tx_state_r == SER_IDLE);
  end

  assign msr_chg_s  = {modem_s[3] ^ msr_r[3], modem_s[2] & ~msr_r[2], modem_s[1] ^ msr_r[1], modem_s[0] ^ msr_r[0]};
  assign thre_set_s = (tx_empty_s & ~tx_empty_d_r) | (ier_wr_s & ~ier_r[IER_THRE] & wr_byte_s[IER_THRE]);
  assign thre_clr_s = thr_wr_s | (iir_rd_s & (iir_code_s == IIR_THRE));

  // Sticky status flags, modem deltas, IRQ and serial output; new events win over read-clears.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lsr_oe_r <= 1'b0;  lsr_fe_r <= 1'b0;  msr_r <= 4'h0;  msr_delta_r <= 4'h0;
      thre_flag_r <= 1'b0;  tx_empty_d_r <= 1'b1;  int_r <= 1'b0;  stx_r <= 1'b1;
    end else begin
      if (rx_ovr_s) lsr_oe_r <= 1'b1; else if (lsr_rd_s) lsr_oe_r <= 1'b0;
      if (rx_push_s && rx_fe_s) lsr_fe_r <= 1'b1; else if (lsr_rd_s) lsr_fe_r <= 1'b0;
      if (thre_set_s) thre_flag_r <= 1'b1; else if (thre_clr_s) thre_flag_r <= 1'b0;
      msr_r        <= modem_s;
      msr_delta_r  <= (msr_delta_r & {4{~msr_rd_s}}) | msr_chg_s;
      tx_empty_d_r <= tx_empty_s;
      int_r        <= ~iir_code_s[0];
      stx_r        <= mcr_r[MCR_LOOP] | tx_line_s;
    end
  end

  // Register read mux.
  always_comb begin
    rd_byte_s = 8'h00;
    case (dp_addr_r)
      REG_RBR: rd_byte_s = dlab_s ? dll_r : (rx_empty_s ? 8'h00 : rx_rdata_s);
      REG_IER: rd_byte_s = dlab_s ? dlm_r : {4'h0, ier_r};
      REG_IIR: rd_byte_s = {4'hC, iir_code_s};
      REG_LCR: rd_byte_s = lcr_r;
      REG_MCR: rd_byte_s = {3'b000, mcr_r};
      REG_LSR: rd_byte_s = lsr_s;
      REG_MSR: rd_byte_s = {msr_r, msr_delta_r};
      REG_SCR: rd_byte_s = scr_r;
      default: rd_byte_s = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ahb_uart16550.sv
// Directed self-checking bench for ahb_uart16550: bus access, TX/RX framing, overrun, loopback, endian.
module tb_ahb_uart16550;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HSEL, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        SI_Endian, UART_SRX, UART_STX, UART_RTS, UART_CTS, UART_DTR;
  logic        UART_DSR, UART_RI, UART_DCD, UART_INT;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic [7:0]  txb;
  logic        found, stx_ok;

  ahb_uart16550 dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .SI_Endian(SI_Endian),
    .UART_SRX(UART_SRX), .UART_STX(UART_STX), .UART_RTS(UART_RTS), .UART_CTS(UART_CTS),
    .UART_DTR(UART_DTR), .UART_DSR(UART_DSR), .UART_RI(UART_RI), .UART_DCD(UART_DCD),
    .UART_INT(UART_INT));

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  // 8N1 frame at divisor 2: 32 HCLK per bit.
  task automatic send_byte(input logic [7:0] b);
    UART_SRX = 1'b0;
    repeat (32) @(negedge HCLK);
    for (int i = 0; i < 8; i++) begin
      UART_SRX = b[i];
      repeat (32) @(negedge HCLK);
    end
    UART_SRX = 1'b1;
    repeat (32) @(negedge HCLK);
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;
    HBURST = 3'd0; HMASTLOCK = 1'b0; HPROT = 4'h0; HSIZE = 3'd0; SI_Endian = 1'b1;
    UART_SRX = 1'b1; UART_CTS = 1'b1; UART_DSR = 1'b1; UART_RI = 1'b1; UART_DCD = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_stx", 32'(UART_STX), 32'h1);
    chk("rst_int", 32'(UART_INT), 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    ahb_read(32'h14, rd); chk("rst_lsr", rd, 32'h00000060);
    ahb_read(32'h08, rd); chk("rst_iir", rd, 32'h000000C1);
    ahb_read(32'h0C, rd); chk("rst_lcr", rd, 32'h00000003);
    chk("hready", 32'(HREADY), 32'h1);
    chk("hresp", 32'(HRESP), 32'h0);
    @(negedge HCLK);
    chk("hrdata_idle", HRDATA, 32'h0);

    // Divisor 2 through DLAB, then confirm DLL readback.
    ahb_write(32'h0C, 32'h83);
    ahb_write(32'h00, 32'h02);
    ahb_write(32'h04, 32'h00);
    ahb_read(32'h00, rd); chk("dll_rb", rd, 32'h02);
    ahb_write(32'h0C, 32'h03);
    ahb_read(32'h00, rd); chk("rbr_empty", rd, 32'h0);

    // Transmit 0x55 and sample each bit at mid-bit.
    txb = 8'h55;
    ahb_write(32'h00, 32'h55);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge HCLK);
      if (UART_STX === 1'b0) found = 1'b1;
    end
    chk("tx_start_seen", 32'(found), 32'h1);
    ahb_read(32'h14, rd); chk("lsr_tx_busy", rd, 32'h20);
    repeat (14) @(negedge HCLK);
    chk("tx_start_bit", 32'(UART_STX), 32'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (32) @(negedge HCLK);
      chk($sformatf("tx_bit%0d", i), 32'(UART_STX), 32'(txb[i]));
    end
    repeat (32) @(negedge HCLK);
    chk("tx_stop_bit", 32'(UART_STX), 32'h1);
    repeat (32) @(negedge HCLK);
    ahb_read(32'h14, rd); chk("lsr_tx_done", rd, 32'h60);

    // Receive 0xA5 and the RDA interrupt.
    send_byte(8'hA5);
    repeat (4) @(negedge HCLK);
    ahb_read(32'h14, rd); chk("lsr_rx_ready", rd, 32'h61);
    ahb_write(32'h04, 32'h01);
    repeat (2) @(negedge HCLK);
    chk("int_rda", 32'(UART_INT), 32'h1);
    ahb_read(32'h08, rd); chk("iir_rda", rd, 32'hC4);
    ahb_read(32'h00, rd); chk("rbr_a5", rd, 32'hA5);
    repeat (2) @(negedge HCLK);
    chk("int_rda_clr", 32'(UART_INT), 32'h0);
    ahb_read(32'h14, rd); chk("lsr_rx_empty", rd, 32'h60);
    ahb_write(32'h04, 32'h00);

    // Overrun: 17 bytes into a 16-entry FIFO.
    for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
    repeat (4) @(negedge HCLK);
    ahb_read(32'h14, rd); chk("lsr_overrun", rd, 32'h63);
    ahb_read(32'h14, rd); chk("lsr_oe_clear", rd, 32'h61);
    for (int i = 0; i < 16; i++) begin
      ahb_read(32'h00, rd);
      chk($sformatf("rbr_ovr%0d", i), rd, 32'h10 + 32'(i));
    end
    ahb_read(32'h14, rd); chk("lsr_drained", rd, 32'h60);

    // THRE interrupt armed by enabling IER[1], cleared by the IIR read that reports it.
    ahb_write(32'h04, 32'h02);
    repeat (2) @(negedge HCLK);
    chk("int_thre", 32'(UART_INT), 32'h1);
    ahb_read(32'h08, rd); chk("iir_thre", rd, 32'hC2);
    repeat (2) @(negedge HCLK);
    chk("int_thre_clr", 32'(UART_INT), 32'h0);
    ahb_read(32'h08, rd); chk("iir_none", rd, 32'hC1);
    ahb_write(32'h04, 32'h00);

    // Loopback.
    ahb_write(32'h10, 32'h10);
    ahb_write(32'h00, 32'h3C);
    stx_ok = 1'b1;
    repeat (400) begin
      @(negedge HCLK);
      if (UART_STX !== 1'b1) stx_ok = 1'b0;
    end
    chk("loop_stx_high", 32'(stx_ok), 32'h1);
    ahb_read(32'h14, rd); chk("loop_lsr", rd, 32'h61);
    ahb_read(32'h00, rd); chk("loop_rbr", rd, 32'h3C);
    ahb_write(32'h10, 32'h12);
    repeat (4) @(negedge HCLK);
    ahb_read(32'h18, rd); chk("loop_msr", rd, 32'h11);
    ahb_read(32'h18, rd); chk("loop_msr_clr", rd, 32'h10);
    chk("rts_pin", 32'(UART_RTS), 32'h0);
    chk("dtr_pin", 32'(UART_DTR), 32'h1);
    ahb_write(32'h10, 32'h00);

    // Byte lane selection.
    SI_Endian = 1'b0;
    ahb_write(32'h1C, 32'h7E000000);
    ahb_read(32'h1C, rd); chk("scr_be", rd, 32'h7E000000);
    ahb_read(32'h14, rd); chk("lsr_be", rd, 32'h60000000);
    SI_Endian = 1'b1;
    ahb_read(32'h1C, rd); chk("scr_le", rd, 32'h0000007E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
